// File: rtl/md_unit_ctrl.sv
// Multiply/divide unit for the EX stage: owns HI/LO and models mult/div latency with a countdown.
// Raises a stall request while an HI/LO-dependent instruction in D must wait.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_md_use_d,
  output logic        o_busy,
  output logic        o_stall_md,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic [31:0] r_sh_hi, w_sh_hi_d;
  logic [31:0] r_sh_lo, w_sh_lo_d;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_rs_mag, w_rt_mag, w_sden, w_uden;
  logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
  logic        w_long_start, w_div_zero;

  assign w_prod_s = $signed({{32{i_rs_val[31]}}, i_rs_val}) *
                    $signed({{32{i_rt_val[31]}}, i_rt_val});
  assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

  // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_rs_mag   = i_rs_val[31] ? (~i_rs_val + 32'd1) : i_rs_val;
  assign w_rt_mag   = i_rt_val[31] ? (~i_rt_val + 32'd1) : i_rt_val;
  assign w_div_zero = (i_rt_val == 32'd0);
  assign w_sden     = w_div_zero ? 32'd1 : w_rt_mag;
  assign w_uden     = w_div_zero ? 32'd1 : i_rt_val;
  assign w_sq_mag   = w_rs_mag / w_sden;
  assign w_sr_mag   = w_rs_mag % w_sden;
  assign w_sq       = (i_rs_val[31] ^ i_rt_val[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
  assign w_sr       = i_rs_val[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;
  assign w_uq       = i_rs_val / w_uden;
  assign w_ur       = i_rs_val % w_uden;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_sh_hi_d = r_sh_hi;
    w_sh_lo_d = r_sh_lo;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          case (i_md_op)
            3'd0: begin
              w_sh_hi_d = w_prod_s[63:32];
              w_sh_lo_d = w_prod_s[31:0];
              w_cnt_d   = MultLoad;
              w_state_d = StRun;
            end
            3'd1: begin
              w_sh_hi_d = w_prod_u[63:32];
              w_sh_lo_d = w_prod_u[31:0];
              w_cnt_d   = MultLoad;
              w_state_d = StRun;
            end
            3'd2: begin
              w_sh_hi_d = w_div_zero ? r_hi : w_sr;
              w_sh_lo_d = w_div_zero ? r_lo : w_sq;
              w_cnt_d   = DivLoad;
              w_state_d = StRun;
            end
            3'd3: begin
              w_sh_hi_d = w_div_zero ? r_hi : w_ur;
              w_sh_lo_d = w_div_zero ? r_lo : w_uq;
              w_cnt_d   = DivLoad;
              w_state_d = StRun;
            end
            3'd4:    w_hi_d = i_rs_val;
            3'd5:    w_lo_d = i_rs_val;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Any start while running is dropped; the hazard unit never issues one.
        if (r_cnt == 4'd1) begin
          w_hi_d    = r_sh_hi;
          w_lo_d    = r_sh_lo;
          w_cnt_d   = 4'd0;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_sh_hi <= 32'd0;
      r_sh_lo <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_sh_hi <= w_sh_hi_d;
      r_sh_lo <= w_sh_lo_d;
    end
  end

  assign w_long_start = i_start & (i_md_op <= 3'd3);
  assign o_busy       = (r_state == StRun);
  assign o_stall_md   = i_md_use_d & (o_busy | w_long_start);
  assign o_hi         = r_hi;
  assign o_lo         = r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: a behavioural model predicts busy/stall/HI/LO each cycle,
// and a monitor compares DUT outputs on the falling clock edge.
module tb_md_unit_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  md_unit_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_md_op    (md_op),
    .i_rs_val   (rs_val),
    .i_rt_val   (rt_val),
    .i_md_use_d (md_use),
    .o_busy     (busy),
    .o_stall_md (stall_md),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: architectural HI/LO, cycles of busy left, result waiting to land.
  int          m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("busy",     {31'd0, busy},     {31'd0, e.busy});
      chk("stall_md", {31'd0, stall_md}, {31'd0, e.stall});
      chk("hi",       hi,                e.hi);
      chk("lo",       lo,                e.lo);
    end
  end

  // Drive one cycle's inputs just after a rising edge; predict outputs and the next edge.
  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic use_d);
    exp_t        e;
    logic [63:0] p;
    longint      a, b, qq, rr;
    @(posedge clk);
    #1;
    rst_n  = rst;
    start  = st;
    md_op  = op;
    rs_val = rs;
    rt_val = rt;
    md_use = use_d;
    if (!rst) begin
      m_rem = 0;
      m_hi  = 0;
      m_lo  = 0;
    end
    e.busy  = (m_rem > 0);
    e.stall = use_d & (e.busy | (st & (op <= 3'd3)));
    e.hi    = m_hi;
    e.lo    = m_lo;
    q.push_back(e);
    if (rst) begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (st) begin
        case (op)
          3'd0: begin
            p = longint'($signed(rs)) * longint'($signed(rt));
            p_hi = p[63:32]; p_lo = p[31:0]; m_rem = MultN;
          end
          3'd1: begin
            p = {32'd0, rs} * {32'd0, rt};
            p_hi = p[63:32]; p_lo = p[31:0]; m_rem = MultN;
          end
          3'd2, 3'd3: begin
            if (rt == 0) begin
              p_hi = m_hi; p_lo = m_lo;
            end else begin
              a  = (op == 3'd2) ? longint'($signed(rs)) : longint'({32'd0, rs});
              b  = (op == 3'd2) ? longint'($signed(rt)) : longint'({32'd0, rt});
              qq = a / b;
              rr = a % b;
              p  = qq;
              p_lo = p[31:0];
              p  = rr;
              p_hi = p[31:0];
            end
            m_rem = DivN;
          end
          3'd4:    m_hi = rs;
          3'd5:    m_lo = rs;
          default: ;
        endcase
      end
    end
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, use_d);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = 0; rt_val = 0; md_use = 1'b0;
    step(1'b0, 1'b0, 3'd0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 0, 0, 1'b0);
    idle(1, 1'b0);
    // mult / multu of -2 and 3
    step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(6, 1'b0);
    step(1'b1, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(6, 1'b0);
    // div / divu and divide by zero with known HI/LO
    step(1'b1, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(11, 1'b0);
    step(1'b1, 1'b1, 3'd3, 32'd7, 32'd2, 1'b0);         idle(11, 1'b0);
    step(1'b1, 1'b1, 3'd4, 32'h11, 0, 1'b0);
    step(1'b1, 1'b1, 3'd5, 32'h22, 0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 32'd99, 32'd0, 1'b0);        idle(11, 1'b0);
    // mthi / mtlo back to back
    step(1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF, 0, 1'b0);
    step(1'b1, 1'b1, 3'd5, 32'h1234_5678, 0, 1'b0);
    idle(1, 1'b0);
    // stall window with and without a dependent instruction in D
    step(1'b1, 1'b1, 3'd0, 32'd6, 32'd7, 1'b1); idle(7, 1'b1);
    step(1'b1, 1'b1, 3'd0, 32'd6, 32'd7, 1'b0); idle(6, 1'b0);
    // starts while a div runs must be dropped
    step(1'b1, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    step(1'b1, 1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
    step(1'b1, 1'b1, 3'd4, 32'hAAAA_5555, 0, 1'b0);
    idle(10, 1'b0);
    // reset in the 4th busy cycle of a div aborts it
    step(1'b1, 1'b1, 3'd2, 32'd1000, 32'd3, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 3'd0, 0, 0, 1'b1);
    idle(12, 1'b0);
    // signed overflow case
    step(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(11, 1'b0);
    // random traffic, including reserved ops and starts during RUN
    for (int i = 0; i < 600; i++) begin
      step(1'b1, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
